// File: rtl/hw_mux_seq_pkg.sv
// ============================================================================
// Module  : hw_mux_seq_pkg
// Purpose : Shared types and constants for the hw_mux_seq sequencer.
//           - sequencer state encoding (IDLE/STEP/DONE, 2-bit)
//           - SEL_LAST, the final select value stepped through
//           - the default operand width
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package hw_mux_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] SEL_LAST   = 2'd3;
  localparam int         DW_DEFAULT = 3;

endpackage

`default_nettype wire

// File: rtl/hw_mux_seq_hold_cnt.sv
// ============================================================================
// Module  : hw_hold_cnt
// Purpose : 8-bit hold-window counter. Counts 0..HOLD-1 while en is high and
//           wraps to 0; tc flags the last cycle of each window.
// Ports   : clk   in  1  system clock
//           rst_n in  1  asynchronous active-low reset
//           clr   in  1  synchronous clear to 0 (priority over en)
//           en    in  1  count enable
//           tc    out 1  terminal count: en high and cnt == HOLD-1
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module hw_hold_cnt #(
  parameter int HOLD = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [7:0] CNT_LAST = 8'(HOLD - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;
  logic       at_last;

  // With HOLD=1 CNT_LAST is 0, so the counter never leaves 0 and tc
  // fires on every enabled cycle.
  assign at_last = (cnt_q == CNT_LAST);
  assign tc      = en && at_last;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 8'd0;
    end else if (en) begin
      cnt_d = at_last ? 8'd0 : cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/hw_mux_seq.sv
// ============================================================================
// Module  : hw_mux_seq
// Purpose : Upstream sequencer for a 2-input / 2-bit-select mux stage.
//           On an accepted start it latches op0/op1 onto din0/din1, steps sel
//           0..3 holding each value HOLD cycles, samples dout_in at the end
//           of every hold window and packs the four samples into result.
// Ports   : clk      in  1     system clock
//           rst_n    in  1     asynchronous active-low reset
//           start    in  1     request, sampled only in IDLE
//           op0/op1  in  DW    operands latched on accept
//           din0/1   out DW    registered mux data drives
//           sel      out 2     registered mux select drive
//           dout_in  in  DW    mux output fed back
//           busy     out 1     high while stepping
//           done     out 1     one-cycle pulse, result valid
//           result   out 4*DW  {s3,s2,s1,s0}
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module hw_mux_seq
  import hw_mux_seq_pkg::*;
#(
  parameter int DW   = DW_DEFAULT,
  parameter int HOLD = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [DW-1:0]   op0,
  input  logic [DW-1:0]   op1,
  output logic [DW-1:0]   din0,
  output logic [DW-1:0]   din1,
  output logic [1:0]      sel,
  input  logic [DW-1:0]   dout_in,
  output logic            busy,
  output logic            done,
  output logic [4*DW-1:0] result
);

  state_t            state_q, state_d;
  logic [DW-1:0]     din0_q, din0_d;
  logic [DW-1:0]     din1_q, din1_d;
  logic [1:0]        sel_q, sel_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [4*DW-1:0]   result_q, result_d;

  logic              accept;
  logic              step_en;
  logic              tc;

  assign accept  = (state_q == IDLE) && start;
  assign step_en = (state_q == STEP);

  hw_hold_cnt #(
    .HOLD (HOLD)
  ) u_hold_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept),
    .en    (step_en),
    .tc    (tc)
  );

  always_comb begin
    state_d  = state_q;
    din0_d   = din0_q;
    din1_d   = din1_q;
    sel_d    = sel_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          din0_d  = op0;
          din1_d  = op1;
          sel_d   = 2'd0;
          busy_d  = 1'b1;
          state_d = STEP;
        end
      end
      STEP: begin
        if (tc) begin
          // Slices are written in place; the old result stays visible in
          // the untouched slices until the run overwrites them.
          result_d[sel_q*DW +: DW] = dout_in;
          if (sel_q == SEL_LAST) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            sel_d = sel_q + 2'd1;
          end
        end
      end
      DONE: begin
        // start is deliberately not looked at here; sel and operands stay.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      din0_q   <= '0;
      din1_q   <= '0;
      sel_q    <= 2'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      din0_q   <= din0_d;
      din1_q   <= din1_d;
      sel_q    <= sel_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign din0   = din0_q;
  assign din1   = din1_q;
  assign sel    = sel_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

`default_nettype wire
